mem_port_arbiter: RTL
=====================

// Module: mem_port_arbiter
// PURPOSE
// Shares one unified memory port between instruction fetch (port 0, IF) and
// load/store (port 1, LSU) of the core pipeline. Fixed priority to LSU with an
// IF anti-starvation counter. An in-order owner-ID FIFO tracks outstanding
// transactions and routes responses. Squashes IF responses on a pipeline flush.
// PARAMETERS
// MAX_OUTST     2   max outstanding memory transactions (ID FIFO depth, >=1)
// STARVE_LIMIT  4   consecutive LSU grants while IF waits before IF is forced
// PORTS
// clk               in   1   core clock
// rst_n             in   1   async active-low reset
// i_flush           in   1   branch/jump taken: drop pending IF responses
// i_if_req_valid    in   1   IF request valid (read only)
// o_if_req_ready    out  1   IF request accepted this cycle
// i_if_addr         in   64  IF fetch address
// o_if_resp_valid   out  1   IF response valid (one cycle)
// o_if_resp_rdata   out  64  IF read data
// i_lsu_req_valid   in   1   LSU request valid
// o_lsu_req_ready   out  1   LSU request accepted this cycle
// i_lsu_addr        in   64  LSU address
// i_lsu_we          in   1   1=store, 0=load
// i_lsu_wdata       in   64  store data
// i_lsu_be          in   8   store byte enables
// o_lsu_resp_valid  out  1   LSU response valid (loads and stores)
// o_lsu_resp_rdata  out  64  LSU read data
// o_mem_req_valid   out  1   memory request valid
// i_mem_req_ready   in   1   memory accepts request
// o_mem_addr/we/wdata/be out 64/1/64/8  muxed request fields (IF: we=0, be=0)
// i_mem_resp_valid  in   1   memory response, strictly in request order
// i_mem_rdata       in   64  memory read data
// o_err             out  1   sticky: response arrived with empty ID FIFO
// BEHAVIOUR
// - Reset: all *_valid/*_ready outputs 0, o_err 0, FIFO empty, starve_cnt 0,
//   lock 0. Request outputs pass-through from selected port (no added latency).
// - Handshake: transfer when valid&ready same cycle. Requesters hold fields
//   stable while valid and not ready.
// - Select (lock=0): only one valid -> that port. Both valid -> LSU, unless
//   starve_cnt==STARVE_LIMIT -> IF. Neither -> o_mem_req_valid=0.
// - Lock: o_mem_req_valid=1 & !i_mem_req_ready registers lock=1 + owner;
//   selection frozen until the handshake, so the memory sees a stable request.
// - o_mem_req_valid = selected valid & !fifo_full. oX_req_ready =
//   grant_X & i_mem_req_ready & !fifo_full. Full blocks push even if a pop
//   occurs the same cycle.
// - starve_cnt: +1 (saturating at STARVE_LIMIT) on each LSU handshake while
//   i_if_req_valid=1; cleared on IF handshake or any cycle i_if_req_valid=0.
// - Push on memory handshake: {owner, drop=0}. Pop on i_mem_resp_valid:
//   route i_mem_rdata to owner's resp port, combinationally same cycle, unless
//   drop=1 (response discarded, no valid pulse). Push+pop same cycle legal.
// - i_flush: sets drop=1 on every IF entry in the FIFO, including one pushed
//   that cycle, and on an IF response popped that cycle (no o_if_resp_valid).
//   A locked IF request still completes; its response is dropped. LSU entries
//   unaffected.
// - i_mem_resp_valid with FIFO empty: ignored, o_err set until reset.
// - FIFO pointers wrap modulo MAX_OUTST; count width $clog2(MAX_OUTST+1).
// - Async reset mid-transaction empties the FIFO. Late responses then hit o_err.
// TESTING
// - IF-only reads A=0x0,0x4, mem_req_ready=1, resp 1 cycle later -> two
//   o_if_resp_valid pulses, in order, with the matching rdata.
// - Both valid from cycle 0, STARVE_LIMIT=4 -> grants L,L,L,L,I,L,L,L,L,I.
// - mem_req_ready low 3 cycles while LSU store pending, then IF raises valid
//   -> request fields constant for all 4 cycles, LSU granted first.
// - MAX_OUTST=2, two handshakes, no responses -> both req_ready=0 until pop.
// - IF read outstanding, i_flush pulse, then resp -> no o_if_resp_valid; the
//   following LSU resp is routed normally.
// - i_mem_resp_valid after reset with nothing issued -> o_err=1 and stays 1.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between IF (port 0) and LSU (port 1): LSU priority with an IF anti-starvation count.
// Requests and responses pass through with no added latency; a stalled request stays locked until accepted.
module mem_port_arbiter #(
  parameter int MAX_OUTST    = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_flush,
  input  logic        i_if_req_valid,
  output logic        o_if_req_ready,
  input  logic [63:0] i_if_addr,
  output logic        o_if_resp_valid,
  output logic [63:0] o_if_resp_rdata,
  input  logic        i_lsu_req_valid,
  output logic        o_lsu_req_ready,
  input  logic [63:0] i_lsu_addr,
  input  logic        i_lsu_we,
  input  logic [63:0] i_lsu_wdata,
  input  logic [7:0]  i_lsu_be,
  output logic        o_lsu_resp_valid,
  output logic [63:0] o_lsu_resp_rdata,
  output logic        o_mem_req_valid,
  input  logic        i_mem_req_ready,
  output logic [63:0] o_mem_addr,
  output logic        o_mem_we,
  output logic [63:0] o_mem_wdata,
  output logic [7:0]  o_mem_be,
  input  logic        i_mem_resp_valid,
  input  logic [63:0] i_mem_rdata,
  output logic        o_err
);

  localparam int PW = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
  localparam int CW = $clog2(MAX_OUTST + 1);
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  typedef enum logic {OWN_IF = 1'b0, OWN_LSU = 1'b1} owner_e;

  logic                 lock_q;
  owner_e               owner_q;
  logic                 pdrop_q;
  logic                 err_q;
  logic [SW-1:0]        starve_q;
  logic [PW-1:0]        wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]        cnt_q;
  owner_e               fifo_own_q [MAX_OUTST];
  logic [MAX_OUTST-1:0] fifo_drop_q;

  owner_e sel;
  logic   sel_vld, full, mem_hs, pop, head_drop, lock_if_nxt;
  owner_e head_own;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(MAX_OUTST - 1)) ? '0 : p + PW'(1);
  endfunction

  always_comb begin
    sel = OWN_IF;
    if (lock_q)
      sel = owner_q;
    else if (i_lsu_req_valid && !(i_if_req_valid && starve_q == SW'(STARVE_LIMIT)))
      sel = OWN_LSU;
  end

  assign sel_vld         = (sel == OWN_LSU) ? i_lsu_req_valid : i_if_req_valid;
  assign full            = (cnt_q == CW'(MAX_OUTST));
  assign o_mem_req_valid = sel_vld & ~full;
  assign mem_hs          = o_mem_req_valid & i_mem_req_ready;
  assign o_if_req_ready  = mem_hs & (sel == OWN_IF);
  assign o_lsu_req_ready = mem_hs & (sel == OWN_LSU);

  assign o_mem_addr  = (sel == OWN_LSU) ? i_lsu_addr : i_if_addr;
  assign o_mem_we    = (sel == OWN_LSU) & i_lsu_we;
  assign o_mem_wdata = (sel == OWN_LSU) ? i_lsu_wdata : '0;
  assign o_mem_be    = (sel == OWN_LSU) ? i_lsu_be : '0;

  // A flush also kills an IF response being popped in the same cycle.
  assign pop       = i_mem_resp_valid & (cnt_q != '0);
  assign head_own  = fifo_own_q[rd_ptr_q];
  assign head_drop = fifo_drop_q[rd_ptr_q] | (i_flush & (head_own == OWN_IF));

  assign o_if_resp_valid  = pop & (head_own == OWN_IF) & ~head_drop;
  assign o_lsu_resp_valid = pop & (head_own == OWN_LSU) & ~head_drop;
  assign o_if_resp_rdata  = i_mem_rdata;
  assign o_lsu_resp_rdata = i_mem_rdata;
  assign o_err            = err_q;

  // IF request that will still be waiting at the port next cycle.
  assign lock_if_nxt = lock_q ? (owner_q == OWN_IF) : (o_mem_req_valid && sel == OWN_IF);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_q      <= 1'b0;
      owner_q     <= OWN_IF;
      pdrop_q     <= 1'b0;
      err_q       <= 1'b0;
      starve_q    <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
      fifo_drop_q <= '0;
      for (int i = 0; i < MAX_OUTST; i++) fifo_own_q[i] <= OWN_IF;
    end else begin
      if (mem_hs) begin
        lock_q  <= 1'b0;
        pdrop_q <= 1'b0;
      end else begin
        if (o_mem_req_valid) begin
          lock_q  <= 1'b1;
          owner_q <= sel;
        end
        if (i_flush && lock_if_nxt) pdrop_q <= 1'b1;
      end

      if (!i_if_req_valid || o_if_req_ready)
        starve_q <= '0;
      else if (o_lsu_req_ready && starve_q != SW'(STARVE_LIMIT))
        starve_q <= starve_q + SW'(1);

      if (i_flush) begin
        for (int i = 0; i < MAX_OUTST; i++)
          if (fifo_own_q[i] == OWN_IF) fifo_drop_q[i] <= 1'b1;
      end
      if (mem_hs) begin
        fifo_own_q[wr_ptr_q]  <= sel;
        fifo_drop_q[wr_ptr_q] <= (sel == OWN_IF) & (i_flush | pdrop_q);
        wr_ptr_q              <= ptr_inc(wr_ptr_q);
      end
      if (pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
      cnt_q <= cnt_q + CW'(mem_hs) - CW'(pop);

      if (i_mem_resp_valid && cnt_q == '0) err_q <= 1'b1;
    end
  end

endmodule
